instr_mem_fetch: RTL and testbench

// Parametrised byte-addressed instruction memory with a valid/ready fetch port and a word-wide program-load port.

---
 rtl/instr_mem_fetch_if.sv | 26 ++
 rtl/instr_mem_fetch.sv | 135 +++++++++++++
 tb/tb_instr_mem_fetch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_fetch_if.sv
// rtl/instr_mem_fetch_if.sv - fetch request/response handshake bundle
// Ports (interface signals):
//   req_valid, req_ready, req_pc           fetch request channel
//   rsp_valid, rsp_ready, rsp_instr, rsp_fault  fetch response channel
// Modports: master = fetch stage side, slave = instruction memory side.
interface instr_mem_fetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic [1:0]        rsp_fault;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - byte-addressed instruction memory with valid/ready fetch and word load port
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   fetch        instr_mem_fetch_if.slave (req_valid/req_ready/req_pc, rsp_valid/rsp_ready/rsp_instr/rsp_fault)
//   flush        discard the pending response; blocks accepts this cycle
//   ld_en        program-load write strobe
//   ld_addr      word-aligned byte address, bits [1:0] ignored
//   ld_data      little-endian write data
//   ld_be        byte enables, ld_be[i] writes mem[addr+i]
//   fetch_count  number of handed-off responses, wrapping
module instr_mem_fetch #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32,
    parameter bit PRELOAD     = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_mem_fetch_if.slave    fetch,
    input  logic                flush,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [31:0]         ld_data,
    input  logic [3:0]          ld_be,
    output logic [CNT_W-1:0]    fetch_count
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] MAX_PC  = ADDR_W'(DEPTH_BYTES - 4);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_BYTES);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic [7:0]  mem [DEPTH_BYTES];
    logic        rsp_valid_q;
    logic [31:0] rsp_instr_q;
    logic [1:0]  rsp_fault_q;

    // Boot program image, one byte at a time so the reset loop can index it.
    function automatic logic [7:0] boot_byte(input int i);
        logic [31:0] w;
        case (i / 4)
            0:       w = 32'h0001_1020;
            1:       w = 32'h0085_3022;
            2:       w = 32'h0109_5024;
            3:       w = 32'h0128_5025;
            4:       w = 32'h0166_0180;
            5:       w = 32'hFD80_0004;
            default: w = 32'h0000_0000;
        endcase
        w = w >> (8 * (i % 4));
        return w[7:0];
    endfunction

    // Read path: combinational lookup so the registered response is ready one edge after accept.
    logic [IDX_W-1:0] rd_idx;
    logic             misaligned;
    logic             out_of_range;
    logic [1:0]       rd_fault;
    logic [31:0]      rd_word;

    assign rd_idx       = fetch.req_pc[IDX_W-1:0];
    assign misaligned   = (fetch.req_pc[1:0] != 2'b00);
    assign out_of_range = (fetch.req_pc > MAX_PC);
    assign rd_fault     = {out_of_range, misaligned};

    always_comb begin
        rd_word = 32'h0;
        if (rd_fault == 2'b00) begin
            rd_word = {mem[rd_idx + IDX_W'(3)], mem[rd_idx + IDX_W'(2)],
                       mem[rd_idx + IDX_W'(1)], mem[rd_idx]};
        end
    end

    logic accept;
    logic handoff;

    assign fetch.req_ready = reset && ((state == EMPTY) || fetch.rsp_ready) && !flush;
    assign accept          = fetch.req_valid && fetch.req_ready;
    assign handoff         = rsp_valid_q && fetch.rsp_ready;

    assign fetch.rsp_valid = rsp_valid_q;
    assign fetch.rsp_instr = rsp_instr_q;
    assign fetch.rsp_fault = rsp_fault_q;

    // Load port: the write lands at the edge, so a same-cycle fetch has already sampled the old bytes.
    logic [IDX_W-1:0] ld_idx;
    logic             ld_ok;

    assign ld_idx = {ld_addr[IDX_W-1:2], 2'b00};
    assign ld_ok  = (ld_addr < DEPTH_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= PRELOAD ? boot_byte(i) : 8'h00;
            end
        end else if (ld_en && ld_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[b]) begin
                    mem[ld_idx + IDX_W'(b)] <= ld_data[8*b +: 8];
                end
            end
        end
    end

    // Single-entry output register. Flush wins over accept (req_ready is already low),
    // but a hand-off in the flush cycle still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 32'h0;
            rsp_fault_q <= 2'b00;
            fetch_count <= '0;
        end else begin
            if (handoff) begin
                fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                state       <= EMPTY;
                rsp_valid_q <= 1'b0;
            end else if (accept) begin
                state       <= FULL;
                rsp_valid_q <= 1'b1;
                rsp_instr_q <= rd_word;
                rsp_fault_q <= rd_fault;
            end else if (handoff) begin
                state       <= EMPTY;
                rsp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb/tb_instr_mem_fetch.sv - directed self-checking bench for instr_mem_fetch
module tb_instr_mem_fetch;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;
    logic [15:0] fetch_count;

    int checks;
    int errors;

    instr_mem_fetch_if #(.ADDR_W(32)) f ();

    instr_mem_fetch #(
        .DEPTH_BYTES(256),
        .ADDR_W(32),
        .PRELOAD(1'b1),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch(f),
        .flush(flush),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_be(ld_be),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; response is checked by the caller after return.
    task automatic fetch_one(input logic [31:0] pc);
        f.req_valid = 1'b1;
        f.req_pc    = pc;
        tick();
        f.req_valid = 1'b0;
    endtask

    logic [31:0] boot [6];
    logic [15:0] cnt_before;

    initial begin
        boot[0] = 32'h0001_1020; boot[1] = 32'h0085_3022; boot[2] = 32'h0109_5024;
        boot[3] = 32'h0128_5025; boot[4] = 32'h0166_0180; boot[5] = 32'hFD80_0004;
        checks = 0;
        errors = 0;

        reset = 1'b0; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;
        f.req_valid = 1'b0; f.req_pc = '0; f.rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset_req_ready", {31'b0, f.req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("reset_rsp_instr", f.rsp_instr, 32'h0);
        chk("reset_rsp_fault", {30'b0, f.rsp_fault}, 32'd0);
        chk("reset_count", {16'b0, fetch_count}, 32'd0);

        reset = 1'b1;
        #1;
        chk("empty_req_ready", {31'b0, f.req_ready}, 32'd1);

        // Boot program streamed at one fetch per cycle.
        f.rsp_ready = 1'b1;
        f.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            f.req_pc = 32'(4 * i);
            tick();
            chk($sformatf("boot_valid_%0d", i), {31'b0, f.rsp_valid}, 32'd1);
            chk($sformatf("boot_instr_%0d", i), f.rsp_instr, boot[i]);
            chk($sformatf("boot_fault_%0d", i), {30'b0, f.rsp_fault}, 32'd0);
        end
        f.req_valid = 1'b0;
        tick();
        chk("boot_count", {16'b0, fetch_count}, 32'd6);
        chk("boot_drained", {31'b0, f.rsp_valid}, 32'd0);

        // Fault classification.
        fetch_one(32'd2);
        chk("mis_fault", {30'b0, f.rsp_fault}, 32'd1);
        chk("mis_instr", f.rsp_instr, 32'h0);
        fetch_one(32'd256);
        chk("oor_fault", {30'b0, f.rsp_fault}, 32'd2);
        chk("oor_instr", f.rsp_instr, 32'h0);
        fetch_one(32'hFFFF_FFFF);
        chk("both_fault", {30'b0, f.rsp_fault}, 32'd3);
        fetch_one(32'd252);
        chk("last_word_fault", {30'b0, f.rsp_fault}, 32'd0);
        chk("last_word_instr", f.rsp_instr, 32'h0);
        tick();
        chk("fault_count", {16'b0, fetch_count}, 32'd10);

        // Backpressure: response held stable, req_ready follows rsp_ready combinationally.
        f.rsp_ready = 1'b0;
        fetch_one(32'd4);
        f.req_pc = 32'd8;
        #1;
        chk("bp_req_ready_low", {31'b0, f.req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_valid_%0d", i), {31'b0, f.rsp_valid}, 32'd1);
            chk($sformatf("bp_instr_%0d", i), f.rsp_instr, 32'h0085_3022);
        end
        f.rsp_ready = 1'b1;
        #1;
        chk("bp_req_ready_high", {31'b0, f.req_ready}, 32'd1);
        tick();
        chk("bp_count", {16'b0, fetch_count}, 32'd11);

        // Same-cycle load and fetch: fetch sees old bytes, refetch sees merged bytes.
        ld_en = 1'b1; ld_addr = 32'd8; ld_data = 32'hA5A5_A5A5; ld_be = 4'b0101;
        f.req_valid = 1'b1; f.req_pc = 32'd8;
        tick();
        ld_en = 1'b0; f.req_valid = 1'b0;
        chk("ld_old_instr", f.rsp_instr, 32'h0109_5024);
        tick();
        fetch_one(32'd8);
        chk("ld_new_instr", f.rsp_instr, 32'h01A5_50A5);
        tick();
        chk("ld_count", {16'b0, fetch_count}, 32'd13);

        // Out-of-range load is dropped, not wrapped onto word 0.
        ld_en = 1'b1; ld_addr = 32'd256; ld_data = 32'hFFFF_FFFF; ld_be = 4'b1111;
        tick();
        ld_en = 1'b0;
        fetch_one(32'd0);
        chk("ld_drop_instr", f.rsp_instr, 32'h0001_1020);
        tick();

        // Flush while FULL with no hand-off.
        f.rsp_ready = 1'b0;
        fetch_one(32'd12);
        chk("fl_pre_instr", f.rsp_instr, 32'h0128_5025);
        cnt_before = fetch_count;
        flush = 1'b1;
        f.req_valid = 1'b1; f.req_pc = 32'd16;
        #1;
        chk("fl_req_ready", {31'b0, f.req_ready}, 32'd0);
        tick();
        flush = 1'b0; f.req_valid = 1'b0;
        chk("fl_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("fl_count", {16'b0, fetch_count}, {16'b0, cnt_before});

        // Flush coinciding with a hand-off still counts it.
        f.rsp_ready = 1'b1;
        fetch_one(32'd16);
        cnt_before = fetch_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flho_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("flho_count", {16'b0, fetch_count}, {16'b0, cnt_before + 16'd1});

        // Asynchronous reset mid-stream; memory returns to the boot image.
        f.rsp_ready = 1'b0;
        fetch_one(32'd4);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, f.req_ready}, 32'd0);
        chk("mid_rst_count", {16'b0, fetch_count}, 32'd0);
        tick();
        reset = 1'b1;
        f.rsp_ready = 1'b1;
        fetch_one(32'd4);
        chk("post_rst_instr4", f.rsp_instr, 32'h0085_3022);
        fetch_one(32'd8);
        chk("post_rst_instr8", f.rsp_instr, 32'h0109_5024);
        chk("post_rst_count", {16'b0, fetch_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
